// File: rtl/alu.sv
// Execute-stage ALU: AND/OR/ADD/SUB with a one-cycle registered result and zero flag.
// Optional carry/overflow/negative outputs are built when ALU_FLAGS_EN is defined.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       ALU_ctrl,
  input  logic [WIDTH-1:0] data_in_A,
  input  logic [WIDTH-1:0] data_in_B,
`ifdef ALU_FLAGS_EN
  output logic             carry,
  output logic             overflow,
  output logic             negative,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             out_valid
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] data_out_d, data_out_q;
  logic             zero_d, zero_q;
  logic             out_valid_d, out_valid_q;

  // ADD and SUB share one adder; SUB is A + ~B + 1 so the top bit is the no-borrow carry.
  always_comb begin
    is_sub  = (ALU_ctrl == OP_SUB);
    b_eff   = is_sub ? ~data_in_B : data_in_B;
    sum_ext = {1'b0, data_in_A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    result  = '0;
    case (ALU_ctrl)
      OP_AND:  result = data_in_A & data_in_B;
      OP_OR:   result = data_in_A | data_in_B;
      default: result = sum_ext[WIDTH-1:0];
    endcase
  end

  always_comb begin
    data_out_d  = data_out_q;
    zero_d      = zero_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      data_out_d = result;
      zero_d     = (result == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q  <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
  logic carry_d, carry_q;
  logic overflow_d, overflow_q;
  logic negative_d, negative_q;
  logic arith;
  logic ovf_raw;

  // Signed overflow: operands (B already inverted for SUB) agree in sign but the result does not.
  always_comb begin
    arith   = (ALU_ctrl == OP_ADD) || (ALU_ctrl == OP_SUB);
    ovf_raw = (data_in_A[WIDTH-1] == b_eff[WIDTH-1]) &&
              (sum_ext[WIDTH-1] != data_in_A[WIDTH-1]);
    carry_d    = carry_q;
    overflow_d = overflow_q;
    negative_d = negative_q;
    if (in_valid) begin
      carry_d    = arith & sum_ext[WIDTH];
      overflow_d = arith & ovf_raw;
      negative_d = result[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      negative_q <= negative_d;
    end
  end

  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign negative = negative_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu; flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   ALU_ctrl = 2'b00;
  logic [W-1:0] data_in_A = '0;
  logic [W-1:0] data_in_B = '0;
  logic [W-1:0] data_out;
  logic         zero;
  logic         out_valid;
`ifdef ALU_FLAGS_EN
  logic         carry, overflow, negative;
`endif

  int errors = 0;
  int checks = 0;

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ALU_ctrl  (ALU_ctrl),
    .data_in_A (data_in_A),
    .data_in_B (data_in_B),
`ifdef ALU_FLAGS_EN
    .carry     (carry),
    .overflow  (overflow),
    .negative  (negative),
`endif
    .data_out  (data_out),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Present inputs on the falling edge, then return 1 time unit after the next rising edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] ctrl, input logic v);
    @(negedge clk);
    data_in_A = a;
    data_in_B = b;
    ALU_ctrl  = ctrl;
    in_valid  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (data_out !== '0 || zero !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: data_out=%0d zero=%b out_valid=%b, want 0/1/0", data_out, zero, out_valid);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({carry, overflow, negative} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: cvn=%b, want 000", {carry, overflow, negative});
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== '0 || zero !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: data_out=%0d zero=%b out_valid=%b, want 0/1/0", data_out, zero, out_valid);
    end
  endtask

  task automatic test_and();
    apply(64'd223, 64'd132, 2'b00, 1'b1);
    checks++;
    if (data_out !== 64'd132 || zero !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL and: data_out=%0d zero=%b out_valid=%b, want 132/0/1", data_out, zero, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    apply(64'd4013, 64'd3022, 2'b01, 1'b1);
    checks++;
    if (data_out !== 64'd4079 || zero !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL or: data_out=%0d zero=%b out_valid=%b, want 4079/0/1", data_out, zero, out_valid);
    end
    apply(64'd5555, 64'd4321, 2'b10, 1'b1);
    checks++;
    if (data_out !== 64'd9876 || zero !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_b2b: data_out=%0d zero=%b out_valid=%b, want 9876/0/1", data_out, zero, out_valid);
    end
  endtask

  task automatic test_sub_zero();
    apply(64'd5, 64'd5, 2'b11, 1'b1);
    checks++;
    if (data_out !== '0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_eq: data_out=%0d zero=%b, want 0/1", data_out, zero);
    end
    apply(64'd999999, 64'd111111, 2'b11, 1'b1);
    checks++;
    if (data_out !== 64'd888888 || zero !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sub: data_out=%0d zero=%b out_valid=%b, want 888888/0/1", data_out, zero, out_valid);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({carry, overflow, negative} !== 3'b100) begin
      errors++;
      $display("FAIL sub_flags: cvn=%b, want 100", {carry, overflow, negative});
    end
`endif
  endtask

  task automatic test_hold();
    apply(64'd12345, 64'd1, 2'b10, 1'b0);
    checks++;
    if (data_out !== 64'd888888 || zero !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold1: data_out=%0d zero=%b out_valid=%b, want 888888/0/0", data_out, zero, out_valid);
    end
    apply(64'd7, 64'd7, 2'b11, 1'b0);
    checks++;
    if (data_out !== 64'd888888 || zero !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold2: data_out=%0d zero=%b out_valid=%b, want 888888/0/0", data_out, zero, out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] ones;
    ones = '1;
    apply(ones, 64'd1, 2'b10, 1'b1);
    checks++;
    if (data_out !== '0 || zero !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_add: data_out=%h zero=%b out_valid=%b, want 0/1/1", data_out, zero, out_valid);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({carry, overflow, negative} !== 3'b100) begin
      errors++;
      $display("FAIL wrap_add_flags: cvn=%b, want 100", {carry, overflow, negative});
    end
`endif
    apply(64'd0, 64'd1, 2'b11, 1'b1);
    checks++;
    if (data_out !== ones || zero !== 1'b0) begin
      errors++;
      $display("FAIL wrap_sub: data_out=%h zero=%b, want all-ones/0", data_out, zero);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({carry, overflow, negative} !== 3'b001) begin
      errors++;
      $display("FAIL wrap_sub_flags: cvn=%b, want 001", {carry, overflow, negative});
    end
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b10, 1'b1);
    checks++;
    if ({carry, overflow, negative} !== 3'b011 || data_out !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL ovf_add: data_out=%h cvn=%b, want 8000000000000000/011", data_out, {carry, overflow, negative});
    end
`endif
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    data_in_A = 64'd7;
    data_in_B = 64'd8;
    ALU_ctrl  = 2'b10;
    in_valid  = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (data_out !== '0 || zero !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: data_out=%0d zero=%b out_valid=%b, want 0/1/0", data_out, zero, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_edge: data_out=%0d out_valid=%b, want 0/0", data_out, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== '0 || zero !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: data_out=%0d zero=%b out_valid=%b, want 0/1/0", data_out, zero, out_valid);
    end
    apply(64'd7, 64'd8, 2'b10, 1'b1);
    checks++;
    if (data_out !== 64'd15 || zero !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_recapture: data_out=%0d zero=%b out_valid=%b, want 15/0/1", data_out, zero, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_back_to_back();
    test_sub_zero();
    test_hold();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
